// File: rtl/coinc_pkg.sv
// Shared types and helpers for the coincidence acquisition sequencer.
package coinc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    ACQUIRE = 2'd2,
    LATCH   = 2'd3
  } state_t;

  localparam int DEF_CNT_W  = 32;
  localparam int DEF_GATE_W = 32;
  localparam int DEF_WIN_W  = 8;

  // Increment v, holding at the all-ones value of a w-bit field (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : (v + 64'd1);
  endfunction

endpackage

// File: rtl/coinc_pair_match.sv
// Pairs pulses from channels A and B that fall within the coincidence
// window. Each pulse pairs at most once; an unpaired pulse waits as
// "pending" until its age passes the window.
module coinc_pair_match
  import coinc_pkg::*;
#(
  parameter int WIN_W = DEF_WIN_W
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             clr,
  input  logic             en,
  input  logic             pulse_a,
  input  logic             pulse_b,
  input  logic [WIN_W-1:0] window,
  output logic             coinc_hit
);

  // One extra bit so an age can always be seen to exceed the window.
  localparam int AGE_W = WIN_W + 1;

  logic             pend_a;
  logic             pend_b;
  logic [AGE_W-1:0] age_a;
  logic [AGE_W-1:0] age_b;
  logic [AGE_W-1:0] age_a_inc;
  logic [AGE_W-1:0] age_b_inc;
  logic [AGE_W-1:0] win_ext;
  logic             same_cycle;
  logic             a_pairs;
  logic             b_pairs;

  // Decide this cycle's pairing from the current pulses and pending state.
  always_comb begin
    win_ext    = {1'b0, window};
    age_a_inc  = AGE_W'(sat_inc(64'(age_a), AGE_W));
    age_b_inc  = AGE_W'(sat_inc(64'(age_b), AGE_W));
    same_cycle = pulse_a & pulse_b;
    a_pairs    = pulse_a & ~pulse_b & pend_b & (age_b <= win_ext);
    b_pairs    = pulse_b & ~pulse_a & pend_a & (age_a <= win_ext);
    coinc_hit  = en & (same_cycle | a_pairs | b_pairs);
  end

  // Pending flags and ages: age holds the separation (in cycles) from the
  // pending pulse to the current cycle, so a fresh pulse reads 1 next cycle.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      age_a  <= '0;
      age_b  <= '0;
    end else if (clr) begin
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      age_a  <= '0;
      age_b  <= '0;
    end else if (en) begin
      if (pulse_a && !pulse_b && !a_pairs) begin
        pend_a <= (window != '0);
        age_a  <= AGE_W'(1);
      end else if (b_pairs) begin
        pend_a <= 1'b0;
      end else if (pend_a) begin
        age_a <= age_a_inc;
        if (age_a_inc > win_ext) pend_a <= 1'b0;
      end

      if (pulse_b && !pulse_a && !b_pairs) begin
        pend_b <= (window != '0);
        age_b  <= AGE_W'(1);
      end else if (a_pairs) begin
        pend_b <= 1'b0;
      end else if (pend_b) begin
        age_b <= age_b_inc;
        if (age_b_inc > win_ext) pend_b <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/coinc_acq_ctrl.sv
// Acquisition sequencer: arms a gate, counts singles and coincidences,
// and latches the results into a valid/ack result port.
module coinc_acq_ctrl
  import coinc_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int GATE_W = DEF_GATE_W,
  parameter int WIN_W  = DEF_WIN_W
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [GATE_W-1:0] cfg_gate_len,
  input  logic [WIN_W-1:0]  cfg_window,
  input  logic              cfg_continuous,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic              pulse_a,
  input  logic              pulse_b,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ack,
  output logic [CNT_W-1:0]  res_singles_a,
  output logic [CNT_W-1:0]  res_singles_b,
  output logic [CNT_W-1:0]  res_coinc,
  output logic              res_overflow,
  output logic [7:0]        res_seq
);

  state_t            state;
  logic [GATE_W-1:0] timer;
  logic [CNT_W-1:0]  cnt_a;
  logic [CNT_W-1:0]  cnt_b;
  logic [CNT_W-1:0]  cnt_c;
  logic              stopped;
  logic              acq_en;
  logic              arm_clr;
  logic              coinc_hit;

  assign acq_en  = (state == ACQUIRE);
  assign arm_clr = (state == ARM);

  coinc_pair_match #(
    .WIN_W (WIN_W)
  ) u_pair_match (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .clr       (arm_clr),
    .en        (acq_en),
    .pulse_a   (pulse_a),
    .pulse_b   (pulse_b),
    .window    (cfg_window),
    .coinc_hit (coinc_hit)
  );

  // Sequencer FSM with counters, gate timer and registered result port.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      busy          <= 1'b0;
      timer         <= '0;
      cnt_a         <= '0;
      cnt_b         <= '0;
      cnt_c         <= '0;
      stopped       <= 1'b0;
      res_valid     <= 1'b0;
      res_singles_a <= '0;
      res_singles_b <= '0;
      res_coinc     <= '0;
      res_overflow  <= 1'b0;
      res_seq       <= '0;
    end else begin
      // A read retires the result; a LATCH below overrides this.
      if (res_ack && res_valid) res_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_start) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end

        ARM: begin
          cnt_a   <= '0;
          cnt_b   <= '0;
          cnt_c   <= '0;
          stopped <= 1'b0;
          timer   <= (cfg_gate_len == '0) ? GATE_W'(1) : cfg_gate_len;
          state   <= ACQUIRE;
        end

        ACQUIRE: begin
          if (pulse_a)   cnt_a <= CNT_W'(sat_inc(64'(cnt_a), CNT_W));
          if (pulse_b)   cnt_b <= CNT_W'(sat_inc(64'(cnt_b), CNT_W));
          if (coinc_hit) cnt_c <= CNT_W'(sat_inc(64'(cnt_c), CNT_W));
          // Stop takes precedence over a coincident timer expiry.
          if (cmd_stop) begin
            stopped <= 1'b1;
            state   <= LATCH;
          end else if (timer == GATE_W'(1)) begin
            state <= LATCH;
          end else begin
            timer <= timer - GATE_W'(1);
          end
        end

        LATCH: begin
          res_singles_a <= cnt_a;
          res_singles_b <= cnt_b;
          res_coinc     <= cnt_c;
          res_seq       <= res_seq + 8'd1;
          res_valid     <= 1'b1;
          res_overflow  <= res_valid && !res_ack;
          if (cfg_continuous && !stopped && !cmd_stop) begin
            state <= ARM;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coinc_acq_ctrl.sv
// Self-checking bench for coinc_acq_ctrl, built with 4-bit counters so
// saturation is reachable in a short gate.
module tb_coinc_acq_ctrl;

  localparam int CNT_W  = 4;
  localparam int GATE_W = 16;
  localparam int WIN_W  = 8;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b1;
  logic [GATE_W-1:0] cfg_gate_len = '0;
  logic [WIN_W-1:0]  cfg_window = '0;
  logic              cfg_continuous = 1'b0;
  logic              cmd_start = 1'b0;
  logic              cmd_stop = 1'b0;
  logic              pulse_a = 1'b0;
  logic              pulse_b = 1'b0;
  logic              busy;
  logic              res_valid;
  logic              res_ack = 1'b0;
  logic [CNT_W-1:0]  res_singles_a;
  logic [CNT_W-1:0]  res_singles_b;
  logic [CNT_W-1:0]  res_coinc;
  logic              res_overflow;
  logic [7:0]        res_seq;

  typedef struct packed {
    logic [CNT_W-1:0] a;
    logic [CNT_W-1:0] b;
    logic [CNT_W-1:0] c;
    logic [7:0]       seq;
    logic             ovf;
  } exp_t;

  exp_t       sb_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         res_cyc = 0;
  logic [7:0] last_seq = '0;

  always #5 ACLK = ~ACLK;

  coinc_acq_ctrl #(
    .CNT_W  (CNT_W),
    .GATE_W (GATE_W),
    .WIN_W  (WIN_W)
  ) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .cfg_gate_len   (cfg_gate_len),
    .cfg_window     (cfg_window),
    .cfg_continuous (cfg_continuous),
    .cmd_start      (cmd_start),
    .cmd_stop       (cmd_stop),
    .pulse_a        (pulse_a),
    .pulse_b        (pulse_b),
    .busy           (busy),
    .res_valid      (res_valid),
    .res_ack        (res_ack),
    .res_singles_a  (res_singles_a),
    .res_singles_b  (res_singles_b),
    .res_coinc      (res_coinc),
    .res_overflow   (res_overflow),
    .res_seq        (res_seq)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
    cyc++;
  endtask

  task automatic push_exp(input int a, input int b, input int c, input int seq, input logic ovf);
    exp_t e;
    e.a   = CNT_W'(a);
    e.b   = CNT_W'(b);
    e.c   = CNT_W'(c);
    e.seq = 8'(seq);
    e.ovf = ovf;
    sb_q.push_back(e);
  endtask

  // Start strobe sampled on the next edge (edge 0); afterwards we are in cycle 1.
  task automatic do_start();
    cmd_start = 1'b1;
    tick();
    start_cyc = cyc;
    cmd_start = 1'b0;
  endtask

  // Run one gate; pa/pb bit k drives a pulse in acquire cycle k. A pulse pair
  // is also driven in the LATCH cycle, which must not be counted.
  task automatic run_gate(input int g, input logic [63:0] pa, input logic [63:0] pb, input int stop_at);
    int n;
    cfg_gate_len = GATE_W'(g);
    do_start();
    tick();
    n = (g == 0) ? 1 : g;
    if (stop_at > 0) n = stop_at;
    for (int k = 1; k <= n; k++) begin
      pulse_a  = pa[k];
      pulse_b  = pb[k];
      cmd_stop = (k == stop_at);
      tick();
    end
    pulse_a  = 1'b1;
    pulse_b  = 1'b1;
    cmd_stop = 1'b0;
    tick();
    pulse_a  = 1'b0;
    pulse_b  = 1'b0;
  endtask

  // Wait (bounded) for a new result, then compare it with the scoreboard head.
  task automatic wait_result(input string name);
    exp_t e;
    int   n;
    n = 0;
    while (!(res_valid && res_seq != last_seq) && n < 12) begin
      tick();
      n++;
    end
    vectors++;
    if (!(res_valid && res_seq != last_seq)) begin
      miscompares++;
      $display("FAIL %s_timeout: res_valid=%0b res_seq=%0d, required a new result within 12 cycles",
               name, res_valid, res_seq);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    res_cyc  = cyc - start_cyc + 1;
    last_seq = res_seq;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s_sb: result appeared (seq=%0d) with no expected entry", name, res_seq);
      return;
    end
    e = sb_q.pop_front();
    vectors += 5;
    if (res_singles_a !== e.a) begin
      miscompares++;
      $display("FAIL %s_singles_a: got %0d, required %0d", name, res_singles_a, e.a);
    end
    if (res_singles_b !== e.b) begin
      miscompares++;
      $display("FAIL %s_singles_b: got %0d, required %0d", name, res_singles_b, e.b);
    end
    if (res_coinc !== e.c) begin
      miscompares++;
      $display("FAIL %s_coinc: got %0d, required %0d", name, res_coinc, e.c);
    end
    if (res_seq !== e.seq) begin
      miscompares++;
      $display("FAIL %s_seq: got %0d, required %0d", name, res_seq, e.seq);
    end
    if (res_overflow !== e.ovf) begin
      miscompares++;
      $display("FAIL %s_overflow: got %0b, required %0b", name, res_overflow, e.ovf);
    end
  endtask

  task automatic ack_result(input string name);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_ack_clears: res_valid=%0b, required 0", name, res_valid);
    end
  endtask

  task automatic check_all_zero(input string name);
    vectors++;
    if ({busy, res_valid, res_singles_a, res_singles_b, res_coinc, res_overflow, res_seq} !== '0) begin
      miscompares++;
      $display("FAIL %s: busy=%0b valid=%0b a=%0d b=%0d c=%0d ovf=%0b seq=%0d, required all 0",
               name, busy, res_valid, res_singles_a, res_singles_b, res_coinc, res_overflow, res_seq);
    end
  endtask

  task automatic test_reset();
    #2 ARESETN = 1'b0;
    tick();
    tick();
    check_all_zero("reset_state");
    ARESETN = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_busy: got %0b, required 0", busy);
    end
  endtask

  task automatic test_basic();
    cfg_window     = 8'd2;
    cfg_continuous = 1'b0;
    push_exp(2, 2, 1, 1, 1'b0);
    run_gate(10, 64'h22, 64'h204, 0);
    wait_result("basic");
    vectors++;
    if (res_cyc !== 13) begin
      miscompares++;
      $display("FAIL basic_latency: res_valid first in cycle %0d, required 13", res_cyc);
    end
    ack_result("basic");
  endtask

  task automatic test_window_zero();
    cfg_window = 8'd0;
    push_exp(2, 2, 1, 2, 1'b0);
    run_gate(8, 64'h18, 64'h28, 0);
    wait_result("window0");
    ack_result("window0");
  endtask

  task automatic test_window_edge();
    cfg_window = 8'd2;
    push_exp(3, 3, 2, 3, 1'b0);
    run_gate(14, 64'h482, 64'h2048, 0);
    wait_result("window_edge");
    ack_result("window_edge");
  endtask

  task automatic test_back_to_back();
    cfg_gate_len   = 16'd4;
    cfg_continuous = 1'b1;
    push_exp(0, 0, 0, 4, 1'b0);
    push_exp(0, 0, 0, 5, 1'b1);
    push_exp(0, 0, 0, 6, 1'b0);
    do_start();
    repeat (6) tick();
    wait_result("cont1");
    repeat (6) tick();
    wait_result("cont2");
    vectors++;
    if (res_cyc !== 13) begin
      miscompares++;
      $display("FAIL cont_period: second result in cycle %0d, required 13", res_cyc);
    end
    repeat (5) tick();
    // Now in the third LATCH cycle: acknowledge and drop continuous mode.
    res_ack        = 1'b1;
    cfg_continuous = 1'b0;
    tick();
    res_ack = 1'b0;
    wait_result("cont3");
    vectors += 2;
    if (res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL cont_ack_at_latch_valid: got %0b, required 1", res_valid);
    end
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL cont_end_busy: got %0b, required 0", busy);
    end
    ack_result("cont3");
  endtask

  task automatic test_stop();
    cfg_continuous = 1'b1;
    push_exp(3, 0, 0, 7, 1'b0);
    run_gate(100, 64'hE, 64'h0, 3);
    wait_result("stop");
    vectors += 2;
    if (res_cyc !== 6) begin
      miscompares++;
      $display("FAIL stop_latency: result in cycle %0d, required 6", res_cyc);
    end
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_busy: got %0b, required 0", busy);
    end
    repeat (3) tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_no_rearm: busy=%0b, required 0", busy);
    end
    cfg_continuous = 1'b0;
    ack_result("stop");
  endtask

  task automatic test_saturate();
    push_exp(15, 0, 0, 8, 1'b0);
    run_gate(30, 64'h1FFFFE, 64'h0, 0);
    wait_result("saturate");
    ack_result("saturate");
  endtask

  task automatic test_gate_zero();
    push_exp(1, 0, 0, 9, 1'b0);
    run_gate(0, 64'h2, 64'h0, 0);
    wait_result("gate0");
    vectors++;
    if (res_cyc !== 4) begin
      miscompares++;
      $display("FAIL gate0_latency: result in cycle %0d, required 4", res_cyc);
    end
    // Result left unacknowledged so the reset test sees it cleared.
  endtask

  task automatic test_reset_mid_gate();
    cfg_gate_len = 16'd50;
    do_start();
    tick();
    pulse_a = 1'b1;
    tick();
    pulse_a = 1'b0;
    tick();
    #2 ARESETN = 1'b0;
    #1;
    check_all_zero("reset_mid_gate");
    sb_q.delete();
    last_seq = '0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    tick();
    cfg_window = 8'd2;
    push_exp(1, 1, 1, 1, 1'b0);
    run_gate(5, 64'h4, 64'h4, 0);
    wait_result("after_reset");
    ack_result("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_window_zero();
    test_window_edge();
    test_back_to_back();
    test_stop();
    test_saturate();
    test_gate_zero();
    test_reset_mid_gate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
